// File: rtl/timer_pkg.sv
// Shared types and constants for the play-timer stopwatch and its seven-segment driver.
// Segment patterns are {dp,g,f,e,d,c,b,a}, active-low, with dp off.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] BCD_LIMIT = 16'h9999;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Four-digit BCD +1; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes render blank.
module seg7_decode
    import timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp_en,
    output logic [7:0] seg_n
);

    logic [7:0] pattern;

    always_comb begin
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        seg_n = {~dp_en, pattern[6:0]};
    end

endmodule

// File: rtl/play_timer_display.sv
// SS.hh BCD stopwatch driven by the divider's 100-Hz wave, with a multiplexed
// common-anode four-digit display driven from the divider's scan select.
module play_timer_display
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit SATURATE    = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_100,
    input  logic [1:0]  clk_scan,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        overflow,
    output logic [3:0]  an_n,
    output logic [7:0]  seg_n
);

    logic [SYNC_STAGES-1:0]      c100_sync;
    logic [SYNC_STAGES-1:0][1:0] scan_sync;
    logic                        c100_prev;
    logic                        tick;
    logic [1:0]                  scan_d;

    state_t state, state_next;
    logic   count_en;
    logic   at_limit;

    logic [3:0] digit;
    logic       dp_en;
    logic       blank;
    logic [7:0] seg_pattern;

    // NOTE: every flop here uses <= so all registers sample pre-edge values,
    // independent of block ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c100_sync <= '0;
            scan_sync <= '0;
            c100_prev <= 1'b0;
        end else begin
            c100_sync <= {c100_sync[SYNC_STAGES-2:0], clk_100};
            scan_sync <= {scan_sync[SYNC_STAGES-2:0], clk_scan};
            c100_prev <= c100_sync[SYNC_STAGES-1];
        end
    end

    assign tick   = c100_sync[SYNC_STAGES-1] & ~c100_prev;
    assign scan_d = scan_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // clear beats pause beats start.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_next = ST_RUN;
                ST_RUN: begin
                    if (pause)                            state_next = ST_PAUSE;
                    else if (tick && at_limit && SATURATE) state_next = ST_DONE;
                end
                ST_PAUSE: if (start) state_next = ST_RUN;
                default:  state_next = state;
            endcase
        end
    end

    // NOTE: each comb output gets an unconditional default so no latch can form.
    always_comb begin
        at_limit = (time_bcd == BCD_LIMIT);
        count_en = (state == ST_RUN) && tick && !pause && !clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_bcd <= 16'h0000;
            overflow <= 1'b0;
            running  <= 1'b0;
        end else begin
            running <= (state_next == ST_RUN);
            if (clear) begin
                time_bcd <= 16'h0000;
                overflow <= 1'b0;
            end else if (count_en) begin
                if (at_limit) overflow <= 1'b1;
                if (!(at_limit && SATURATE)) time_bcd <= bcd_inc(time_bcd);
            end
        end
    end

    always_comb begin
        case (scan_d)
            2'd0:    digit = time_bcd[3:0];
            2'd1:    digit = time_bcd[7:4];
            2'd2:    digit = time_bcd[11:8];
            default: digit = time_bcd[15:12];
        endcase
        dp_en = (scan_d == 2'd2);
        blank = BLANK_LZ && (scan_d == 2'd3) && (time_bcd[15:12] == 4'd0);
    end

    seg7_decode u_seg7 (
        .digit (digit),
        .dp_en (dp_en),
        .seg_n (seg_pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n  <= 4'b1111;
            seg_n <= SEG_BLANK;
        end else begin
            an_n  <= ~(4'b0001 << scan_d);
            seg_n <= blank ? SEG_BLANK : seg_pattern;
        end
    end

endmodule

// File: tb/tb_play_timer_display.sv
// Stopwatch/display bench: a saturating and a wrapping instance share stimulus;
// expected results are queued when stimulus is driven and popped when observed.
module tb_play_timer_display;

    localparam int SS = 2;

    typedef struct packed {
        logic [15:0] t;
        logic        run;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } disp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_100 = 1'b0;
    logic [1:0]  clk_scan = 2'd0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;

    logic [15:0] time_s, time_w;
    logic        run_s, run_w, ovf_s, ovf_w;
    logic [3:0]  an_s, an_w;
    logic [7:0]  seg_s, seg_w;

    exp_t  sb_sat[$];
    exp_t  sb_wrap[$];
    disp_t sb_disp[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    play_timer_display #(.SYNC_STAGES(SS), .SATURATE(1'b1), .BLANK_LZ(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clk_100(clk_100), .clk_scan(clk_scan),
        .start(start), .pause(pause), .clear(clear),
        .time_bcd(time_s), .running(run_s), .overflow(ovf_s),
        .an_n(an_s), .seg_n(seg_s)
    );

    play_timer_display #(.SYNC_STAGES(SS), .SATURATE(1'b0), .BLANK_LZ(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .clk_100(clk_100), .clk_scan(clk_scan),
        .start(start), .pause(pause), .clear(clear),
        .time_bcd(time_w), .running(run_w), .overflow(ovf_w),
        .an_n(an_w), .seg_n(seg_w)
    );

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) clk_100 = 1'b1;
            @(negedge clk);
            @(negedge clk) clk_100 = 1'b0;
            @(negedge clk);
        end
    endtask

    // One clk_100 edge with start/pause held in exactly the cycle the tick is live.
    task automatic tick_with(input logic s, input logic p);
        @(negedge clk) clk_100 = 1'b1;
        @(negedge clk);
        @(negedge clk) begin clk_100 = 1'b0; start = s; pause = p; end
        @(negedge clk) begin start = 1'b0; pause = 1'b0; end
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        @(negedge clk) begin start = s; pause = p; clear = c; end
        @(negedge clk) begin start = 1'b0; pause = 1'b0; clear = 1'b0; end
    endtask

    task automatic expect_both(input exp_t es, input exp_t ew);
        sb_sat.push_back(es);
        sb_wrap.push_back(ew);
    endtask

    task automatic compare_sb(input string name);
        exp_t es, ew;
        es = sb_sat.pop_front();
        ew = sb_wrap.pop_front();
        checks++;
        if ({time_s, run_s, ovf_s} !== es) begin
            errors++;
            $display("FAIL %s/sat: got t=%h run=%b ovf=%b expected t=%h run=%b ovf=%b",
                     name, time_s, run_s, ovf_s, es.t, es.run, es.ovf);
        end
        checks++;
        if ({time_w, run_w, ovf_w} !== ew) begin
            errors++;
            $display("FAIL %s/wrap: got t=%h run=%b ovf=%b expected t=%h run=%b ovf=%b",
                     name, time_w, run_w, ovf_w, ew.t, ew.run, ew.ovf);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        expect_both('{16'h0000, 1'b0, 1'b0}, '{16'h0000, 1'b0, 1'b0});
        compare_sb("reset_state");
        checks++;
        if ({an_s, seg_s, an_w, seg_w} !== {4'b1111, 8'hFF, 4'b1111, 8'hFF}) begin
            errors++;
            $display("FAIL reset_display: got an=%b seg=%h / an=%b seg=%h expected an=1111 seg=ff",
                     an_s, seg_s, an_w, seg_w);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_count150;
        pulse(1, 0, 0);
        tick_n(150);
        expect_both('{16'h0150, 1'b1, 1'b0}, '{16'h0150, 1'b1, 1'b0});
        compare_sb("count150");
    endtask

    task automatic test_coincident;
        pulse(0, 0, 1);
        tick_with(1'b1, 1'b0);
        expect_both('{16'h0000, 1'b1, 1'b0}, '{16'h0000, 1'b1, 1'b0});
        compare_sb("start_with_tick");
        tick_n(49);
        expect_both('{16'h0049, 1'b1, 1'b0}, '{16'h0049, 1'b1, 1'b0});
        compare_sb("count49");
        tick_with(1'b0, 1'b1);
        expect_both('{16'h0049, 1'b0, 1'b0}, '{16'h0049, 1'b0, 1'b0});
        compare_sb("pause_with_tick");
        tick_n(2);
        expect_both('{16'h0049, 1'b0, 1'b0}, '{16'h0049, 1'b0, 1'b0});
        compare_sb("paused_hold");
        pulse(1, 0, 0);
        tick_n(1);
        expect_both('{16'h0050, 1'b1, 1'b0}, '{16'h0050, 1'b1, 1'b0});
        compare_sb("resume");
        pulse(1, 1, 0);
        expect_both('{16'h0050, 1'b0, 1'b0}, '{16'h0050, 1'b0, 1'b0});
        compare_sb("start_pause_same_cycle");
    endtask

    task automatic test_limit;
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        tick_n(9999);
        expect_both('{16'h9999, 1'b1, 1'b0}, '{16'h9999, 1'b1, 1'b0});
        compare_sb("preload_9999");
        tick_n(1);
        expect_both('{16'h9999, 1'b0, 1'b1}, '{16'h0000, 1'b1, 1'b1});
        compare_sb("limit_tick");
        pulse(1, 0, 0);
        tick_n(1);
        expect_both('{16'h9999, 1'b0, 1'b1}, '{16'h0001, 1'b1, 1'b1});
        compare_sb("start_in_done");
        pulse(0, 0, 1);
        expect_both('{16'h0000, 1'b0, 1'b0}, '{16'h0000, 1'b0, 1'b0});
        compare_sb("clear_after_limit");
    endtask

    task automatic test_display;
        disp_t prev, exp_d;
        logic [3:0] an_tbl [4];
        logic [7:0] seg_tbl [4];
        an_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tbl = '{8'hA4, 8'hF9, 8'h78, 8'hFF};
        pulse(1, 0, 0);
        tick_n(712);
        pulse(0, 1, 0);
        expect_both('{16'h0712, 1'b0, 1'b0}, '{16'h0712, 1'b0, 1'b0});
        compare_sb("preload_0712");
        @(negedge clk) clk_scan = 2'd3;
        repeat (5) @(negedge clk);
        prev = '{4'b0111, 8'hFF};
        for (int d = 0; d < 4; d++) begin
            @(negedge clk) clk_scan = 2'(d);
            sb_disp.push_back('{an_tbl[d], seg_tbl[d]});
            repeat (SS) @(posedge clk);
            #1;
            checks++;
            if ({an_s, seg_s} !== prev) begin
                errors++;
                $display("FAIL display_early d=%0d: got an=%b seg=%h expected an=%b seg=%h",
                         d, an_s, seg_s, prev.an, prev.seg);
            end
            @(posedge clk);
            #1;
            exp_d = sb_disp.pop_front();
            checks++;
            if ({an_s, seg_s, an_w, seg_w} !== {exp_d, exp_d}) begin
                errors++;
                $display("FAIL display d=%0d: got an=%b seg=%h / an=%b seg=%h expected an=%b seg=%h",
                         d, an_s, seg_s, an_w, seg_w, exp_d.an, exp_d.seg);
            end
            prev = exp_d;
        end
    endtask

    task automatic test_reset_midrun;
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        tick_n(1234);
        expect_both('{16'h1234, 1'b1, 1'b0}, '{16'h1234, 1'b1, 1'b0});
        compare_sb("preload_1234");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        expect_both('{16'h0000, 1'b0, 1'b0}, '{16'h0000, 1'b0, 1'b0});
        compare_sb("async_reset");
        checks++;
        if ({an_s, seg_s, an_w, seg_w} !== {4'b1111, 8'hFF, 4'b1111, 8'hFF}) begin
            errors++;
            $display("FAIL async_reset_display: got an=%b seg=%h / an=%b seg=%h expected an=1111 seg=ff",
                     an_s, seg_s, an_w, seg_w);
        end
        @(negedge clk) clk_100 = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        clk_100 = 1'b0;
        repeat (4) @(negedge clk);
        expect_both('{16'h0000, 1'b0, 1'b0}, '{16'h0000, 1'b0, 1'b0});
        compare_sb("no_count_after_reset");
        pulse(1, 0, 0);
        tick_n(1);
        expect_both('{16'h0001, 1'b1, 1'b0}, '{16'h0001, 1'b1, 1'b0});
        compare_sb("restart_after_reset");
    endtask

    initial begin
        test_reset();
        test_count150();
        test_coincident();
        test_limit();
        test_display();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
